// File: rtl/fetch_unit_if.sv
// Fetch unit handshake bundle: redirect input, instruction-memory request/response
// channels and the decoded-instruction output stream.
interface fetch_unit_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [31:0] pc;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
             imem_rsp_data, inst_ready,
      output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
             imem_rsp_data, inst_ready,
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with an in-order instruction buffer.
// Optional FETCH_STALL_CNT_EN adds a saturating count of cycles with no instruction available.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   fetch_unit_if.master    bus
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0]     stall_cnt
`endif
);
   localparam int         PW       = $clog2(BUF_DEPTH);
   localparam logic [PW:0] LP_DEPTH = (PW+1)'(BUF_DEPTH);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]    r_state;
   logic [31:0]   r_pc;
   logic [31:0]   r_req_pc;
   logic [31:0]   r_buf_data [BUF_DEPTH];
   logic [31:0]   r_buf_pc   [BUF_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [PW:0]   r_cnt;

   logic w_req_valid;
   logic w_req_hs;
   logic w_push;
   logic w_pop;
   logic w_inst_valid;
   logic w_unused;

   assign w_inst_valid = (r_cnt != '0);
   assign w_req_valid  = !rst && (r_state == S_FETCH) && (r_cnt < LP_DEPTH) && !bus.redirect_valid;
   assign w_req_hs     = w_req_valid && bus.imem_req_ready;
   assign w_push       = (r_state == S_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
   assign w_pop        = w_inst_valid && bus.inst_ready && !bus.redirect_valid;
   assign w_unused     = &{1'b0, bus.redirect_pc[1:0]};

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_pc;
   assign bus.pc             = r_pc;
   assign bus.inst_valid     = w_inst_valid;
   assign bus.inst_data      = r_buf_data[r_rd_ptr];
   assign bus.inst_pc        = r_buf_pc[r_rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_FETCH;
         r_pc     <= RESET_PC;
         r_req_pc <= '0;
      end else begin
         case (r_state)
            S_FETCH: if (w_req_hs) r_state <= S_WAIT;
            S_WAIT: begin
               // a response coinciding with a redirect is the stale one: drop it, no FLUSH needed
               if (bus.imem_rsp_valid)      r_state <= S_FETCH;
               else if (bus.redirect_valid) r_state <= S_FLUSH;
            end
            S_FLUSH: if (bus.imem_rsp_valid) r_state <= S_FETCH;
            default: r_state <= S_FETCH;
         endcase
         if (bus.redirect_valid) begin
            r_pc <= {bus.redirect_pc[31:2], 2'b00};
         end else if (w_req_hs) begin
            r_pc     <= r_pc + 32'd4;
            r_req_pc <= r_pc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_buf_data[i] <= '0;
            r_buf_pc[i]   <= '0;
         end
      end else if (bus.redirect_valid) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_buf_data[r_wr_ptr] <= bus.imem_rsp_data;
            r_buf_pc[r_wr_ptr]   <= r_req_pc;
            r_wr_ptr             <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    r_stall_cnt <= '0;
      else if (!w_inst_valid && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: fetch PC loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; legal values 2 and 4.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port redirect_valid  input  1  load a new fetch PC and flush.
REQ-006 Port redirect_pc  input  32  target PC for redirect.
REQ-007 Port imem_req_valid  output  1  instruction-memory read request.
REQ-008 Port imem_req_ready  input  1  memory accepts the request.
REQ-009 Port imem_req_addr  output  32  request address.
REQ-010 Port imem_rsp_valid  input  1  read data valid; cannot be back-pressured.
REQ-011 Port imem_rsp_data  input  32  returned instruction word.
REQ-012 Port inst_valid  output  1  buffer head holds an instruction.
REQ-013 Port inst_ready  input  1  downstream accepts the head.
REQ-014 Port inst_data  output  32  head instruction word.
REQ-015 Port inst_pc  output  32  PC of the head instruction.
REQ-016 Port pc  output  32  next fetch PC.

Function
REQ-017 The block SHALL run a 3-state FSM: FETCH, WAIT, FLUSH.
REQ-018 In FETCH, imem_req_valid SHALL be 1 iff buffer occupancy < BUF_DEPTH and redirect_valid = 0; imem_req_addr SHALL equal pc.
REQ-019 On an imem_req_valid & imem_req_ready handshake, the block SHALL latch pc as req_pc, advance pc by 4 (mod 2^32, 32'hFFFFFFFC wraps to 0), and enter WAIT.
REQ-020 In WAIT and FLUSH, imem_req_valid SHALL be 0; at most one request is outstanding at any time.
REQ-021 In WAIT, imem_rsp_valid SHALL push {req_pc, imem_rsp_data} into the buffer and return the FSM to FETCH in the next cycle.
REQ-022 In FLUSH, imem_rsp_valid SHALL discard the response and return to FETCH.
REQ-023 The block SHALL ignore imem_rsp_valid in FETCH.
REQ-024 Buffer: in-order FIFO; inst_valid = (occupancy != 0); inst_data/inst_pc = head; a pop occurs on inst_valid & inst_ready; push and pop in the same cycle SHALL both take effect.
REQ-025 Redirect: pc SHALL load {redirect_pc[31:2], 2'b00} and the buffer SHALL empty, overriding any same-cycle push or pop.
REQ-026 Redirect in WAIT without same-cycle imem_rsp_valid SHALL enter FLUSH; with same-cycle imem_rsp_valid the response is dropped and the FSM enters FETCH.
REQ-027 Redirect in FETCH SHALL stay in FETCH; redirect in FLUSH SHALL stay in FLUSH.
REQ-028 Latency: an instruction SHALL appear on inst_valid the cycle after its imem_rsp_valid; peak throughput is one instruction per two cycles.

Reset
REQ-029 While rst = 1: pc = RESET_PC, FSM = FETCH, buffer empty, imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0, imem_req_addr = RESET_PC.
REQ-030 Reset asserted mid-transaction SHALL abandon the outstanding request; a late response after reset release while in FETCH is ignored per REQ-023.

Configuration
REQ-031 With macro FETCH_STALL_CNT_EN defined, the block SHALL add output stall_cnt (32 bits), which increments each cycle with inst_valid = 0, saturates at 32'hFFFFFFFF, and resets to 0.
REQ-032 Without FETCH_STALL_CNT_EN, port stall_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset release, imem_req_ready = 1, response 1 cycle later with 32'h00000013, inst_ready = 1 -> requests to 0x0, 0x4, 0x8, ...; inst_pc sequence 0x0, 0x4; one instruction every 2 cycles.
REQ-034 inst_ready = 0 for 10 cycles, BUF_DEPTH = 2 -> exactly 2 requests are issued (0x0, 0x4); imem_req_valid stays 0 until the first pop.
REQ-035 Redirect to 32'h00001002 while in WAIT, response arrives 2 cycles later -> response discarded, next request address 32'h00001000, buffer empty.
REQ-036 Redirect in the same cycle as imem_rsp_valid and inst_valid & inst_ready -> buffer empty next cycle, FSM in FETCH, pc = redirect target.
REQ-037 pc = 32'hFFFFFFFC accepted -> pc wraps to 32'h00000000; with FETCH_STALL_CNT_EN, stall_cnt = 0 at reset and increments while inst_valid = 0.
